// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/XOR/NOR) between two requesters.
// Optional grant counters are enabled with `define LOGIC_ARB_STATS_EN.
module logic_unit_arbiter #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OP_W-1:0]  req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             rsp_zero
`ifdef LOGIC_ARB_STATS_EN
    ,
    output logic [15:0]      gnt0_count,
    output logic [15:0]      gnt1_count
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [OP_W-1:0] OP_AND = 2'b00;
    localparam logic [OP_W-1:0] OP_OR  = 2'b01;
    localparam logic [OP_W-1:0] OP_XOR = 2'b10;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_id_q, rsp_id_d;

    logic             can_issue;
    logic             grant_vld;
    logic             grant_id;
    logic             accept;
    logic [OP_W-1:0]  sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] result;

    function automatic logic [WIDTH-1:0] logic_op(
        input logic [OP_W-1:0]  op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = ~(a | b);
        endcase
        return r;
    endfunction

    // Reset is qualified in here so no ready escapes while reset is held.
    always_comb begin
        can_issue = ~reset & ((state_q == IDLE) | ((state_q == HOLD) & rsp_ready));
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (can_issue) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = ~last_grant_q;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = grant_vld & (grant_id == 1'b0);
    assign req1_ready = grant_vld & (grant_id == 1'b1);
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    assign sel_op = grant_id ? req1_op : req0_op;
    assign sel_a  = grant_id ? req1_a  : req0_a;
    assign sel_b  = grant_id ? req1_b  : req0_b;
    assign result = logic_op(sel_op, sel_a, sel_b);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (rsp_ready && !accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            rsp_data_d   = result;
            rsp_id_d     = grant_id;
            last_grant_d = grant_id;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign rsp_valid = (state_q == HOLD);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_zero  = (rsp_data_q == '0);

`ifdef LOGIC_ARB_STATS_EN
    logic [15:0] gnt0_count_q, gnt0_count_d;
    logic [15:0] gnt1_count_q, gnt1_count_d;

    // Counters saturate rather than wrap so a long run never reads as a short one.
    always_comb begin
        gnt0_count_d = gnt0_count_q;
        gnt1_count_d = gnt1_count_q;
        if (req0_valid && req0_ready && (gnt0_count_q != 16'hFFFF)) begin
            gnt0_count_d = gnt0_count_q + 16'd1;
        end
        if (req1_valid && req1_ready && (gnt1_count_q != 16'hFFFF)) begin
            gnt1_count_d = gnt1_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt0_count_q <= 16'd0;
            gnt1_count_q <= 16'd0;
        end else begin
            gnt0_count_q <= gnt0_count_d;
            gnt1_count_q <= gnt1_count_d;
        end
    end

    assign gnt0_count = gnt0_count_q;
    assign gnt1_count = gnt1_count_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter; define LOGIC_ARB_STATS_EN to also test the grant counters.
module tb_logic_unit_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [1:0]  req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [1:0]  req1_op;
    logic [31:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_id, rsp_zero;
`ifdef LOGIC_ARB_STATS_EN
    logic [15:0] gnt0_count, gnt1_count;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic_unit_arbiter #(.WIDTH(32), .OP_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_zero   (rsp_zero)
`ifdef LOGIC_ARB_STATS_EN
        ,
        .gnt0_count (gnt0_count),
        .gnt1_count (gnt1_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0_valid = 1'b0; req0_op = 2'b00; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 2'b00; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            compared++;
            if (rsp_valid !== 1'b0 || rsp_zero !== 1'b1 || req0_ready !== 1'b0 ||
                req1_ready !== 1'b0 || rsp_data !== 32'h0 || rsp_id !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_idle cyc%0d: valid=%b zero=%b r0=%b r1=%b data=%h id=%b, want 0 1 0 0 0 0",
                         i, rsp_valid, rsp_zero, req0_ready, req1_ready, rsp_data, rsp_id);
            end
            $display("reset cycle %0d: rsp_valid=%b rsp_zero=%b", i, rsp_valid, rsp_zero);
        end
    endtask

    task automatic test_contention();
        logic        exp_g;
        logic [31:0] exp_d;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'h0000_FFFF; req0_b = 32'hFF00_0000;
        req1_valid = 1'b1; req1_op = 2'b10; req1_a = 32'hAAAA_AAAA; req1_b = 32'hFFFF_0000;
        for (int i = 0; i < 6; i++) begin
            exp_g = i[0];
            exp_d = exp_g ? 32'h5555_AAAA : 32'hFF00_FFFF;
            #1;
            compared++;
            if (req0_ready !== ~exp_g || req1_ready !== exp_g) begin
                mismatched++;
                $display("FAIL contention_grant %0d: r0=%b r1=%b, want r0=%b r1=%b",
                         i, req0_ready, req1_ready, ~exp_g, exp_g);
            end
            step();
            compared++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_g || rsp_data !== exp_d) begin
                mismatched++;
                $display("FAIL contention_rsp %0d: valid=%b id=%b data=%h, want 1 %b %h",
                         i, rsp_valid, rsp_id, rsp_data, exp_g, exp_d);
            end
            $display("contention %0d: grant=%b rsp_id=%b rsp_data=%h", i, exp_g, rsp_id, rsp_data);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        compared++;
        if (rsp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL contention_drain: rsp_valid=%b, want 0", rsp_valid);
        end
    endtask

    task automatic test_single_op();
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'hF0F0_1234; req0_b = 32'h0FF0_FFFF;
        #1;
        compared++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL single_ready: r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0;
        compared++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h00F0_1234 || rsp_id !== 1'b0 || rsp_zero !== 1'b0) begin
            mismatched++;
            $display("FAIL single_rsp: valid=%b data=%h id=%b zero=%b, want 1 00f01234 0 0",
                     rsp_valid, rsp_data, rsp_id, rsp_zero);
        end
        $display("single AND: rsp_data=%h rsp_id=%b", rsp_data, rsp_id);
        step();
        compared++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h00F0_1234) begin
            mismatched++;
            $display("FAIL single_drain: valid=%b data=%h, want 0 00f01234", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_backpressure();
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'hFFFF_FFFF; req0_b = 32'h1234_5678;
        step();
        req0_valid = 1'b0;
        rsp_ready  = 1'b0;
        req1_valid = 1'b1; req1_op = 2'b11; req1_a = 32'h0; req1_b = 32'h0;
        for (int i = 0; i < 4; i++) begin
            #1;
            compared++;
            if (req1_ready !== 1'b0 || req0_ready !== 1'b0 || rsp_valid !== 1'b1 ||
                rsp_data !== 32'h1234_5678 || rsp_id !== 1'b0) begin
                mismatched++;
                $display("FAIL backpressure_hold %0d: r1=%b r0=%b valid=%b data=%h id=%b, want 0 0 1 12345678 0",
                         i, req1_ready, req0_ready, rsp_valid, rsp_data, rsp_id);
            end
            $display("backpressure %0d: rsp_data=%h req1_ready=%b", i, rsp_data, req1_ready);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        compared++;
        if (req1_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL backpressure_release_ready: r1=%b, want 1", req1_ready);
        end
        step();
        req1_valid = 1'b0;
        compared++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFF || rsp_id !== 1'b1) begin
            mismatched++;
            $display("FAIL backpressure_nor: valid=%b data=%h id=%b, want 1 ffffffff 1",
                     rsp_valid, rsp_data, rsp_id);
        end
        $display("backpressure release: rsp_data=%h rsp_id=%b", rsp_data, rsp_id);
    endtask

    task automatic test_xor_zero_reset();
        rsp_ready  = 1'b1;
        req1_valid = 1'b1; req1_op = 2'b10; req1_a = 32'hDEAD_BEEF; req1_b = 32'hDEAD_BEEF;
        step();
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        compared++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0 || rsp_zero !== 1'b1 || rsp_id !== 1'b1) begin
            mismatched++;
            $display("FAIL xor_zero: valid=%b data=%h zero=%b id=%b, want 1 00000000 1 1",
                     rsp_valid, rsp_data, rsp_zero, rsp_id);
        end
        $display("xor zero: rsp_data=%h rsp_zero=%b", rsp_data, rsp_zero);
        // Load a nonzero held result so the async clear is observable on every field.
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'h0000_00F0; req0_b = 32'h0000_000F;
        step();
        req0_valid = 1'b0;
        rsp_ready  = 1'b0;
        #2 reset = 1'b1;
        req0_valid = 1'b1;
        #1;
        compared++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_zero !== 1'b1 ||
            req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset: valid=%b data=%h zero=%b r0=%b r1=%b, want 0 00000000 1 0 0",
                     rsp_valid, rsp_data, rsp_zero, req0_ready, req1_ready);
        end
        $display("async reset in HOLD: rsp_valid=%b", rsp_valid);
        req0_valid = 1'b0;
        step();
        #2 reset = 1'b0;
        step();
    endtask

`ifdef LOGIC_ARB_STATS_EN
    task automatic test_stats();
        compared++;
        if (gnt0_count !== 16'd0 || gnt1_count !== 16'd0) begin
            mismatched++;
            $display("FAIL stats_reset: g0=%h g1=%h, want 0000 0000", gnt0_count, gnt1_count);
        end
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'h1; req0_b = 32'h1;
        repeat (65535) step();
        compared++;
        if (gnt0_count !== 16'hFFFF || gnt1_count !== 16'd0) begin
            mismatched++;
            $display("FAIL stats_preload: g0=%h g1=%h, want ffff 0000", gnt0_count, gnt1_count);
        end
        step();
        req0_valid = 1'b0;
        compared++;
        if (gnt0_count !== 16'hFFFF || gnt1_count !== 16'd0) begin
            mismatched++;
            $display("FAIL stats_saturate: g0=%h g1=%h, want ffff 0000", gnt0_count, gnt1_count);
        end
        $display("stats: gnt0_count=%h gnt1_count=%h", gnt0_count, gnt1_count);
    endtask
`endif

    initial begin
        test_reset();
        test_contention();
        test_single_op();
        test_backpressure();
        test_xor_zero_reset();
`ifdef LOGIC_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
